// File: rtl/lm07_spi_responder.sv
// lm07_spi_responder: LM07-compatible SPI temperature responder, oversampled cs_n/sck, 16-bit word MSB-first on sio.
module lm07_spi_responder #(
  parameter int WORD_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sck,
  output logic              sio,
  output logic              sio_oe,
  input  logic [WORD_W-1:0] temp_word,
  input  logic              temp_valid,
  output logic              temp_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);
  localparam int CW = $clog2(WORD_W) + 1;
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  logic [1:0] state;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, fill;
  logic cs_p, sck_p, cs_ok;
  logic [WORD_W-1:0] shift_reg, word_reg, pending;
  logic pending_valid;
  logic [CW-1:0] bit_cnt;
  logic cs_s, sck_s, cs_fall, cs_rise, sck_fall, accept;
  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  // a cs_n that is already low when reset releases must not look like a fresh fall
  assign cs_fall = cs_ok & cs_p & ~cs_s;
  assign cs_rise = ~cs_p & cs_s;
  assign sck_fall = sck_p & ~sck_s;
  assign accept = temp_valid & ~pending_valid;
  assign temp_ready = ~pending_valid;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync <= '1;
      sck_sync <= '0;
      fill <= '0;
      cs_p <= 1'b1;
      sck_p <= 1'b0;
      cs_ok <= 1'b0;
      state <= IDLE;
      shift_reg <= '0;
      word_reg <= '0;
      pending <= '0;
      pending_valid <= 1'b0;
      bit_cnt <= '0;
      sio <= 1'b0;
      sio_oe <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      cs_p <= cs_s;
      sck_p <= sck_s;
      cs_ok <= cs_ok | (fill[SYNC_STAGES-1] & cs_s);
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
      if (state == IDLE) begin
        if (accept) word_reg <= temp_word;
        if (cs_fall) begin
          shift_reg <= accept ? temp_word : word_reg;
          sio <= accept ? temp_word[WORD_W-1] : word_reg[WORD_W-1];
          bit_cnt <= '0;
          sio_oe <= 1'b1;
          state <= ARMED;
        end
      end else if (cs_rise) begin
        state <= IDLE;
        sio <= 1'b0;
        sio_oe <= 1'b0;
        frame_abort <= state != DONE;
        pending_valid <= 1'b0;
        if (pending_valid) word_reg <= pending;
        else if (accept) word_reg <= temp_word;
      end else begin
        if (accept) begin
          pending <= temp_word;
          pending_valid <= 1'b1;
        end
        if (sck_fall && state != DONE) begin
          shift_reg <= shift_reg << 1;
          bit_cnt <= bit_cnt + 1'b1;
          sio <= bit_cnt == LAST ? 1'b0 : shift_reg[WORD_W-2];
          state <= bit_cnt == LAST ? DONE : SHIFT;
          frame_done <= bit_cnt == LAST;
        end
      end
    end
  end
endmodule

// File: tb/tb_lm07_spi_responder.sv
// tb_lm07_spi_responder: directed SPI-master bench for lm07_spi_responder.
module tb_lm07_spi_responder;
  logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, temp_valid = 1'b0;
  logic [15:0] temp_word = '0;
  logic sio, sio_oe, temp_ready, busy, frame_done, frame_abort;
  logic [31:0] rx;
  int checks = 0, errors = 0, done_cnt = 0, abort_cnt = 0;
  int d0, a0;

  lm07_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sio(sio), .sio_oe(sio_oe),
    .temp_word(temp_word), .temp_valid(temp_valid), .temp_ready(temp_ready),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic load(input logic [15:0] w);
    @(negedge clk);
    temp_word = w;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    rx = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // master samples sio just before driving the sck rise
  task automatic bits(input int n);
    for (int i = 0; i < n; i++) begin
      rx = {rx[30:0], sio};
      sck = 1'b1;
      repeat (6) @(negedge clk);
      sck = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sio, sio_oe, temp_ready, busy, frame_done, frame_abort} !== 6'b001000) begin
      errors++;
      $display("FAIL reset outputs: got %b want 001000", {sio, sio_oe, temp_ready, busy, frame_done, frame_abort});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    load(16'h0D1F);
    d0 = done_cnt; a0 = abort_cnt;
    cs_low();
    checks++;
    if (sio_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic oe/busy: got %b%b want 11", sio_oe, busy);
    end
    bits(16);
    cs_high();
    checks++;
    if (rx[15:0] !== 16'h0D1F) begin
      errors++;
      $display("FAIL basic data: got %h want 0d1f", rx[15:0]);
    end
    checks++;
    if (done_cnt - d0 != 1 || abort_cnt - a0 != 0) begin
      errors++;
      $display("FAIL basic pulses: got done=%0d abort=%0d want 1 0", done_cnt - d0, abort_cnt - a0);
    end
    checks++;
    if (busy !== 1'b0 || sio_oe !== 1'b0 || sio !== 1'b0) begin
      errors++;
      $display("FAIL basic idle: got busy=%b oe=%b sio=%b want 0 0 0", busy, sio_oe, sio);
    end
  endtask

  task automatic test_back_to_back();
    load(16'h241F);
    for (int k = 0; k < 2; k++) begin
      cs_low();
      bits(16);
      cs_high();
      checks++;
      if (rx[15:0] !== 16'h241F) begin
        errors++;
        $display("FAIL back_to_back frame %0d: got %h want 241f", k, rx[15:0]);
      end
    end
  endtask

  task automatic test_midload();
    load(16'h0D1F);
    cs_low();
    bits(4);
    temp_word = 16'h101F;
    temp_valid = 1'b1;
    checks++;
    if (temp_ready !== 1'b1) begin
      errors++;
      $display("FAIL midload ready_before: got %b want 1", temp_ready);
    end
    @(negedge clk);
    temp_valid = 1'b0;
    temp_word = 16'h0000;
    checks++;
    if (temp_ready !== 1'b0) begin
      errors++;
      $display("FAIL midload ready_after: got %b want 0", temp_ready);
    end
    bits(12);
    cs_high();
    checks++;
    if (rx[15:0] !== 16'h0D1F || temp_ready !== 1'b1) begin
      errors++;
      $display("FAIL midload current: got %h ready=%b want 0d1f ready=1", rx[15:0], temp_ready);
    end
    cs_low();
    bits(16);
    cs_high();
    checks++;
    if (rx[15:0] !== 16'h101F) begin
      errors++;
      $display("FAIL midload next: got %h want 101f", rx[15:0]);
    end
  endtask

  task automatic test_abort();
    d0 = done_cnt; a0 = abort_cnt;
    cs_low();
    bits(5);
    cs_high();
    checks++;
    if (rx[4:0] !== 5'b00010) begin
      errors++;
      $display("FAIL abort partial: got %b want 00010", rx[4:0]);
    end
    checks++;
    if (abort_cnt - a0 != 1 || done_cnt - d0 != 0 || sio_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort pulses: got abort=%0d done=%0d oe=%b want 1 0 0", abort_cnt - a0, done_cnt - d0, sio_oe);
    end
    cs_low();
    bits(16);
    cs_high();
    checks++;
    if (rx[15:0] !== 16'h101F) begin
      errors++;
      $display("FAIL abort refetch: got %h want 101f", rx[15:0]);
    end
  endtask

  task automatic test_overclock();
    load(16'hFFFF);
    d0 = done_cnt;
    cs_low();
    bits(20);
    checks++;
    if (busy !== 1'b1 || sio !== 1'b0) begin
      errors++;
      $display("FAIL overclock done_state: got busy=%b sio=%b want 1 0", busy, sio);
    end
    cs_high();
    checks++;
    if (rx[19:0] !== 20'hFFFF0) begin
      errors++;
      $display("FAIL overclock data: got %h want ffff0", rx[19:0]);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL overclock done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    load(16'hA5C3);
    cs_low();
    bits(8);
    checks++;
    if (rx[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL reset_mid partial: got %h want a5", rx[7:0]);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sio, sio_oe, temp_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b want 0010", {sio, sio_oe, temp_ready, busy});
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sio_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid no_restart: got busy=%b oe=%b want 0 0", busy, sio_oe);
    end
    cs_high();
    load(16'h5A3C);
    d0 = done_cnt;
    cs_low();
    bits(16);
    cs_high();
    checks++;
    if (rx[15:0] !== 16'h5A3C || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL reset_mid full: got %h done=%0d want 5a3c 1", rx[15:0], done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_midload();
    test_abort();
    test_overclock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
